cache_access_sequencer: RTL
===========================

# cache_access_sequencer

Multi-cycle FSM that sequences a single CPU-side request through the two-level cache hierarchy: L1 lookup, then L2 lookup, then a main-memory transaction. It drives refill/update strobes into the external L1/L2 arrays and returns one response per request. It also keeps saturating hit/miss statistics. It sits between the request source and the L1/L2 tag/data arrays plus the memory port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 8, data width
- OFF_BITS, 6, block offset bits (both levels)
- L1_IDX_BITS, 8, L1 index bits (256 sets)
- L2_IDX_BITS, 12, L2 index bits (4096 sets)
- CNT_W, 16, statistics counter width
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake; transfer when both are high at a rising edge
- req_addr  in  ADDR_W  request address
- req_rw  in  1  0 = read, 1 = write
- req_wdata  in  DATA_W  write data
- l1_index / l2_index  out  L1_IDX_BITS / L2_IDX_BITS  array read index from the registered address
- l1_valid, l1_tag, l1_data  in  1, ADDR_W, DATA_W  L1 array read, combinational from l1_index
- l2_valid, l2_tag, l2_data  in  1, ADDR_W, DATA_W  L2 array read, same rule
- l1_fill_en / l2_fill_en  out  1  one-cycle write strobe to the array at the current index
- fill_tag_l1 / fill_tag_l2  out  ADDR_W  tag to write
- fill_data  out  DATA_W  data to write
- mem_req, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  memory request
- mem_ack, mem_rdata  in  1, DATA_W  memory completion, with read data valid in the same cycle
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_data  out  DATA_W  read data; 0 for writes
- resp_src  out  2  0 = L1, 1 = L2, 2 = MEM
- cnt_clr  in  1  synchronous clear of all counters
- l1_hit_cnt, l1_miss_cnt, l2_hit_cnt, l2_miss_cnt  out  CNT_W  statistics

## Operation
- States: IDLE, L1_LOOK, L2_LOOK, MEM, RESP.
- IDLE
  - req_ready = 1 only in this state.
  - On handshake: register addr, rw and wdata, then go to L1_LOOK.
- Address decode, from the registered address:
  - index = (addr >> OFF_BITS) masked to the index width.
  - tag = addr >> (OFF_BITS + IDX_BITS).
  - hit = valid & (stored tag == tag).
- L1_LOOK
  - Increment l1_hit_cnt or l1_miss_cnt.
  - Read hit: go to RESP, src = L1, data = l1_data.
  - Otherwise (read miss, or any write): go to L2_LOOK.
  - For writes, latch the L1 hit flag.
- L2_LOOK
  - Increment l2_hit_cnt or l2_miss_cnt.
  - Read hit: go to RESP, src = L2, data = l2_data, schedule an L1 fill.
  - Read miss, or any write: go to MEM.
  - For writes, latch the L2 hit flag.
- MEM
  - mem_req = 1, with mem_addr, mem_we = rw and mem_wdata held stable until mem_ack is sampled high.
  - On ack: go to RESP, src = MEM.
  - Reads capture mem_rdata and schedule both L1 and L2 fills.
- Write policy: write-through, no-allocate.
  - A write always goes to memory.
  - fill_en is asserted in RESP only for the levels whose latched hit flag is set, with fill_data = wdata.
- RESP
  - resp_valid = 1, fill strobes per the scheduled fills, fill_tag = the computed tags.
  - Then return to IDLE.
- Counters saturate at all-ones.
  - cnt_clr wins over a simultaneous increment.

## Timing
- All outputs are registered or state-decoded from registers.
- Reset values:
  - State: IDLE.
  - req_ready = 1.
  - All strobes, resp_valid and mem_req = 0.
  - All data, address, tag and counter outputs = 0.
- Handshake accepted at edge k. Latency from k to resp_valid:
  - L1 read hit: resp_valid high during cycle k+2.
  - L2 read hit: k+3.
  - Memory access: k+3+N, where N is the number of MEM cycles (N ≥ 1; an ack in the first MEM cycle gives N = 1).
- Next req_ready is high in the cycle after RESP, so at most one request is in flight.
- mem_ack outside MEM is ignored.
- Reset asserted mid-operation: all outputs return to their reset values immediately and asynchronously, including mem_req dropping; the pending request is discarded.

## Structure
- Package cache_seq_pkg holds:
  - the state enum;
  - RESP_SRC_L1 = 0, RESP_SRC_L2 = 1, RESP_SRC_MEM = 2;
  - default widths.
- Sub-module sat_counter (parameterised CNT_W, inputs inc and clr), instantiated four times.

## Test plan
- Read 0x0001_2340 with L1 valid at index 0x8D and l1_tag = 4 -> l1_index = 0x8D; resp_valid at k+2, resp_src = 0, resp_data = l1_data; l1_hit_cnt = 1.
- Same address, L1 invalid, L2 valid at index 0x48D with tag 0 and data 0x5A -> resp at k+3, src = 1, data = 0x5A; l1_fill_en pulse with fill_tag_l1 = 4, fill_data = 0x5A.
- Read, both levels miss, mem_ack after 3 MEM cycles with rdata 0xC3 -> mem_req high for exactly 3 cycles; resp at k+6, src = 2, data = 0xC3; both fill strobes pulse; both miss counters = 1.
- Write 0x77, L1 hit and L2 miss -> mem_we = 1 with mem_wdata = 0x77; in RESP, l1_fill_en = 1 and l2_fill_en = 0; resp_data = 0.
- Preload counters to 0xFFFF and do an L1 hit -> l1_hit_cnt stays 0xFFFF; assert cnt_clr together with an increment -> counter = 0.
- Assert rst_n low while in MEM -> mem_req = 0 immediately; then a late mem_ack in IDLE produces no resp_valid and no fill.

Source files
------------

// File: rtl/cache_access_sequencer_pkg.sv
// Shared types and default widths for the L1/L2/memory request sequencer.
// Response-source codes match the resp_src encoding seen by the requester.
package cache_seq_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 8;
    localparam int OFF_BITS_DEF    = 6;
    localparam int L1_IDX_BITS_DEF = 8;
    localparam int L2_IDX_BITS_DEF = 12;
    localparam int CNT_W_DEF       = 16;

    localparam logic [1:0] RESP_SRC_L1  = 2'd0;
    localparam logic [1:0] RESP_SRC_L2  = 2'd1;
    localparam logic [1:0] RESP_SRC_MEM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_LOOK,
        ST_L2_LOOK,
        ST_MEM,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/cache_access_sequencer_if.sv
// Request/response, L1/L2 array and memory-port signals of the sequencer.
// The slave modport is the sequencer; master is everything around it.
interface cache_seq_if #(
    parameter int ADDR_W      = cache_seq_pkg::ADDR_W_DEF,
    parameter int DATA_W      = cache_seq_pkg::DATA_W_DEF,
    parameter int L1_IDX_BITS = cache_seq_pkg::L1_IDX_BITS_DEF,
    parameter int L2_IDX_BITS = cache_seq_pkg::L2_IDX_BITS_DEF
);
    import cache_seq_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_addr;
    logic                   req_rw;
    logic [DATA_W-1:0]      req_wdata;
    logic [L1_IDX_BITS-1:0] l1_index;
    logic [L2_IDX_BITS-1:0] l2_index;
    logic                   l1_valid;
    logic [ADDR_W-1:0]      l1_tag;
    logic [DATA_W-1:0]      l1_data;
    logic                   l2_valid;
    logic [ADDR_W-1:0]      l2_tag;
    logic [DATA_W-1:0]      l2_data;
    logic                   l1_fill_en;
    logic                   l2_fill_en;
    logic [ADDR_W-1:0]      fill_tag_l1;
    logic [ADDR_W-1:0]      fill_tag_l2;
    logic [DATA_W-1:0]      fill_data;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_ack;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   resp_valid;
    logic [DATA_W-1:0]      resp_data;
    logic [1:0]             resp_src;

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata,
        input  l1_valid, l1_tag, l1_data, l2_valid, l2_tag, l2_data,
        input  mem_ack, mem_rdata,
        output req_ready, l1_index, l2_index, l1_fill_en, l2_fill_en,
        output fill_tag_l1, fill_tag_l2, fill_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output resp_valid, resp_data, resp_src
    );

    modport master (
        output req_valid, req_addr, req_rw, req_wdata,
        output l1_valid, l1_tag, l1_data, l2_valid, l2_tag, l2_data,
        output mem_ack, mem_rdata,
        input  req_ready, l1_index, l2_index, l1_fill_en, l2_fill_en,
        input  fill_tag_l1, fill_tag_l2, fill_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  resp_valid, resp_data, resp_src
    );

endinterface

// File: rtl/cache_access_sequencer_sat_counter.sv
// Saturating statistics counter; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = cache_seq_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    import cache_seq_pkg::*;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/cache_access_sequencer.sv
// Sequences one request through L1, L2 and memory; write-through, no-allocate.
// Fills are scheduled during lookup and strobed together with the response.
module cache_access_sequencer #(
    parameter int ADDR_W      = cache_seq_pkg::ADDR_W_DEF,
    parameter int DATA_W      = cache_seq_pkg::DATA_W_DEF,
    parameter int OFF_BITS    = cache_seq_pkg::OFF_BITS_DEF,
    parameter int L1_IDX_BITS = cache_seq_pkg::L1_IDX_BITS_DEF,
    parameter int L2_IDX_BITS = cache_seq_pkg::L2_IDX_BITS_DEF,
    parameter int CNT_W       = cache_seq_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_seq_if.slave       bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] l1_hit_cnt,
    output logic [CNT_W-1:0] l1_miss_cnt,
    output logic [CNT_W-1:0] l2_hit_cnt,
    output logic [CNT_W-1:0] l2_miss_cnt
);
    import cache_seq_pkg::*;

    localparam int L1_TAG_SH = OFF_BITS + L1_IDX_BITS;
    localparam int L2_TAG_SH = OFF_BITS + L2_IDX_BITS;

    seq_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              rw_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic [DATA_W-1:0] fill_data_reg;
    logic [1:0]        resp_src_reg;
    logic              fill_l1_reg;
    logic              fill_l2_reg;
    logic [ADDR_W-1:0] tag_l1, tag_l2;
    logic              l1_hit, l2_hit;
    logic [3:0]        cnt_inc;
    logic [CNT_W-1:0]  cnt_val [4];

    assign tag_l1 = addr_reg >> L1_TAG_SH;
    assign tag_l2 = addr_reg >> L2_TAG_SH;
    assign l1_hit = bus.l1_valid && (bus.l1_tag == tag_l1);
    assign l2_hit = bus.l2_valid && (bus.l2_tag == tag_l2);

    assign bus.l1_index    = addr_reg[OFF_BITS +: L1_IDX_BITS];
    assign bus.l2_index    = addr_reg[OFF_BITS +: L2_IDX_BITS];
    assign bus.fill_tag_l1 = tag_l1;
    assign bus.fill_tag_l2 = tag_l2;
    assign bus.fill_data   = fill_data_reg;
    assign bus.resp_data   = resp_data_reg;
    assign bus.resp_src    = resp_src_reg;
    assign bus.mem_we      = rw_reg;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_wdata   = wdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_req    = 1'b0;
        bus.l1_fill_en = 1'b0;
        bus.l2_fill_en = 1'b0;
        cnt_inc        = '0;
        case (state_reg)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = ST_L1_LOOK;
            end
            ST_L1_LOOK: begin
                cnt_inc[0] = l1_hit;
                cnt_inc[1] = !l1_hit;
                state_next = (l1_hit && !rw_reg) ? ST_RESP : ST_L2_LOOK;
            end
            ST_L2_LOOK: begin
                cnt_inc[2] = l2_hit;
                cnt_inc[3] = !l2_hit;
                state_next = (l2_hit && !rw_reg) ? ST_RESP : ST_MEM;
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.l1_fill_en = fill_l1_reg;
                bus.l2_fill_en = fill_l2_reg;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Writes keep resp_data at 0 and fill with their own data; reads overwrite both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            rw_reg        <= 1'b0;
            wdata_reg     <= '0;
            resp_data_reg <= '0;
            fill_data_reg <= '0;
            resp_src_reg  <= RESP_SRC_L1;
            fill_l1_reg   <= 1'b0;
            fill_l2_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_reg      <= bus.req_addr;
                        rw_reg        <= bus.req_rw;
                        wdata_reg     <= bus.req_wdata;
                        resp_data_reg <= '0;
                        fill_data_reg <= bus.req_rw ? bus.req_wdata : '0;
                        fill_l1_reg   <= 1'b0;
                        fill_l2_reg   <= 1'b0;
                    end
                end
                ST_L1_LOOK: begin
                    if (rw_reg) begin
                        fill_l1_reg <= l1_hit;
                    end else if (l1_hit) begin
                        resp_data_reg <= bus.l1_data;
                        resp_src_reg  <= RESP_SRC_L1;
                    end
                end
                ST_L2_LOOK: begin
                    if (rw_reg) begin
                        fill_l2_reg <= l2_hit;
                    end else if (l2_hit) begin
                        resp_data_reg <= bus.l2_data;
                        fill_data_reg <= bus.l2_data;
                        fill_l1_reg   <= 1'b1;
                        resp_src_reg  <= RESP_SRC_L2;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ack) begin
                        resp_src_reg <= RESP_SRC_MEM;
                        if (!rw_reg) begin
                            resp_data_reg <= bus.mem_rdata;
                            fill_data_reg <= bus.mem_rdata;
                            fill_l1_reg   <= 1'b1;
                            fill_l2_reg   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter order: L1 hit, L1 miss, L2 hit, L2 miss.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    assign l1_hit_cnt  = cnt_val[0];
    assign l1_miss_cnt = cnt_val[1];
    assign l2_hit_cnt  = cnt_val[2];
    assign l2_miss_cnt = cnt_val[3];

endmodule
